// File: rtl/hazard_control_unit.sv
// Pipeline stall/flush/bubble sequencer: load-use, branch flush, mul/div occupancy, DMEM wait.
// Control outputs are combinational from state and inputs; stallCnt is a registered saturating count.
module hazard_control_unit #(
    parameter int CNT_W      = 32,
    parameter int MD_TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       rs1Id,
    input  logic [4:0]       rs2Id,
    input  logic             useRs1Id,
    input  logic             useRs2Id,
    input  logic [4:0]       rdEx,
    input  logic             memReadEx,
    input  logic             branchTakenEx,
    input  logic             mulDivStartEx,
    input  logic             mulDivDone,
    input  logic             memAccessMem,
    input  logic             dmemReady,
    input  logic             clrStallCnt,
    output logic             stallIf,
    output logic             stallId,
    output logic             stallEx,
    output logic             stallMem,
    output logic             flushId,
    output logic             bubbleEx,
    output logic             bubbleMem,
    output logic             mulDivAbort,
    output logic [CNT_W-1:0] stallCnt
);

    localparam int MD_W = $clog2(MD_TIMEOUT + 1);
    localparam logic [MD_W-1:0] MD_LAST = MD_W'(MD_TIMEOUT - 1);

    typedef enum logic {RUN, MULDIV} state_t;

    state_t            state_q, state_d;
    logic              done_seen_q, done_seen_d;
    logic [MD_W-1:0]   md_cnt_q, md_cnt_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    logic mem_wait, load_use, md_done;
    logic stall_if, stall_id, stall_ex, stall_mem;
    logic flush_id, bubble_ex, bubble_mem, md_abort;

    assign mem_wait = memAccessMem & ~dmemReady;
    assign load_use = memReadEx && (rdEx != 5'd0) &&
                      ((useRs1Id && (rs1Id == rdEx)) || (useRs2Id && (rs2Id == rdEx)));
    assign md_done  = mulDivDone | done_seen_q;

    always_comb begin
        state_d     = state_q;
        done_seen_d = done_seen_q;
        md_cnt_d    = md_cnt_q;
        stall_if    = 1'b0;
        stall_id    = 1'b0;
        stall_ex    = 1'b0;
        stall_mem   = 1'b0;
        flush_id    = 1'b0;
        bubble_ex   = 1'b0;
        bubble_mem  = 1'b0;
        md_abort    = 1'b0;

        if (mem_wait) begin
            // Whole pipe frozen; a done pulse arriving now must not be lost.
            stall_if  = 1'b1;
            stall_id  = 1'b1;
            stall_ex  = 1'b1;
            stall_mem = 1'b1;
            if (state_q == MULDIV && mulDivDone) begin
                done_seen_d = 1'b1;
            end
        end else if (state_q == RUN) begin
            if (branchTakenEx) begin
                flush_id  = 1'b1;
                bubble_ex = 1'b1;
            end else if (mulDivStartEx) begin
                stall_if   = 1'b1;
                stall_id   = 1'b1;
                stall_ex   = 1'b1;
                bubble_mem = 1'b1;
                state_d    = MULDIV;
                md_cnt_d   = '0;
            end else if (load_use) begin
                stall_if  = 1'b1;
                stall_id  = 1'b1;
                bubble_ex = 1'b1;
            end
        end else begin
            if (md_done) begin
                state_d     = RUN;
                done_seen_d = 1'b0;
                md_cnt_d    = '0;
            end else if (md_cnt_q == MD_LAST) begin
                md_abort    = 1'b1;
                state_d     = RUN;
                done_seen_d = 1'b0;
                md_cnt_d    = '0;
            end else begin
                stall_if   = 1'b1;
                stall_id   = 1'b1;
                stall_ex   = 1'b1;
                bubble_mem = 1'b1;
                md_cnt_d   = md_cnt_q + MD_W'(1);
            end
        end

        if (clrStallCnt) begin
            stall_cnt_d = '0;
        end else if (stall_if && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= RUN;
            done_seen_q <= 1'b0;
            md_cnt_q    <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            done_seen_q <= done_seen_d;
            md_cnt_q    <= md_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stallIf     = rst_n & stall_if;
    assign stallId     = rst_n & stall_id;
    assign stallEx     = rst_n & stall_ex;
    assign stallMem    = rst_n & stall_mem;
    assign flushId     = rst_n & flush_id;
    assign bubbleEx    = rst_n & bubble_ex;
    assign bubbleMem   = rst_n & bubble_mem;
    assign mulDivAbort = rst_n & md_abort;
    assign stallCnt    = stall_cnt_q;

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed bench for hazard_control_unit: single-cycle vector table plus multi-cycle sequences.
module tb_hazard_control_unit;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] rs1Id, rs2Id, rdEx;
    logic       useRs1Id, useRs2Id, memReadEx, branchTakenEx, mulDivStartEx;
    logic       mulDivDone, memAccessMem, dmemReady, clrStallCnt;
    logic       stallIf, stallId, stallEx, stallMem, flushId, bubbleEx, bubbleMem, mulDivAbort;
    logic [3:0] stallCnt;
    logic [7:0] outs;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    hazard_control_unit #(.CNT_W(4), .MD_TIMEOUT(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .rs1Id(rs1Id), .rs2Id(rs2Id), .useRs1Id(useRs1Id), .useRs2Id(useRs2Id),
        .rdEx(rdEx), .memReadEx(memReadEx), .branchTakenEx(branchTakenEx),
        .mulDivStartEx(mulDivStartEx), .mulDivDone(mulDivDone),
        .memAccessMem(memAccessMem), .dmemReady(dmemReady), .clrStallCnt(clrStallCnt),
        .stallIf(stallIf), .stallId(stallId), .stallEx(stallEx), .stallMem(stallMem),
        .flushId(flushId), .bubbleEx(bubbleEx), .bubbleMem(bubbleMem),
        .mulDivAbort(mulDivAbort), .stallCnt(stallCnt)
    );

    // {stallIf, stallId, stallEx, stallMem, flushId, bubbleEx, bubbleMem, mulDivAbort}
    assign outs = {stallIf, stallId, stallEx, stallMem, flushId, bubbleEx, bubbleMem, mulDivAbort};

    localparam logic [7:0] O_NONE = 8'b0000_0000;
    localparam logic [7:0] O_LU   = 8'b1100_0100;
    localparam logic [7:0] O_BR   = 8'b0000_1100;
    localparam logic [7:0] O_MD   = 8'b1110_0010;
    localparam logic [7:0] O_MW   = 8'b1111_0000;
    localparam logic [7:0] O_AB   = 8'b0000_0001;

    typedef struct {
        logic [4:0] rs1, rs2, rd;
        logic       u1, u2, mr, br, md, done, ma, rdy;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs [13];

    task automatic chk(input string nm, input logic [7:0] exp);
        checks++;
        if (outs !== exp) begin
            errors++;
            $display("FAIL %s: outputs got %b expected %b", nm, outs, exp);
        end
    endtask

    task automatic chk_cnt(input string nm, input logic [3:0] exp);
        checks++;
        if (stallCnt !== exp) begin
            errors++;
            $display("FAIL %s: stallCnt got %0d expected %0d", nm, stallCnt, exp);
        end
    endtask

    task automatic clear_inputs();
        rs1Id = 5'd0; rs2Id = 5'd0; rdEx = 5'd0;
        useRs1Id = 1'b0; useRs2Id = 1'b0; memReadEx = 1'b0; branchTakenEx = 1'b0;
        mulDivStartEx = 1'b0; mulDivDone = 1'b0; memAccessMem = 1'b0;
        dmemReady = 1'b1; clrStallCnt = 1'b0;
    endtask

    // Called right after a negedge; returns right after the next negedge with rst_n high.
    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic next_cycle();
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        //            rs1    rs2    rd     u1 u2 mr br md dn ma rdy exp
        vecs[0]  = '{5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0, 0, 1, O_NONE};
        vecs[1]  = '{5'd0, 5'd5, 5'd5, 0, 1, 1, 0, 0, 0, 0, 1, O_LU};
        vecs[2]  = '{5'd7, 5'd0, 5'd7, 1, 0, 1, 0, 0, 0, 0, 1, O_LU};
        vecs[3]  = '{5'd0, 5'd0, 5'd0, 1, 1, 1, 0, 0, 0, 0, 1, O_NONE};
        vecs[4]  = '{5'd7, 5'd0, 5'd7, 0, 0, 1, 0, 0, 0, 0, 1, O_NONE};
        vecs[5]  = '{5'd7, 5'd0, 5'd7, 1, 0, 0, 0, 0, 0, 0, 1, O_NONE};
        vecs[6]  = '{5'd6, 5'd3, 5'd7, 1, 1, 1, 0, 0, 0, 0, 1, O_NONE};
        vecs[7]  = '{5'd5, 5'd0, 5'd5, 1, 0, 1, 1, 0, 0, 0, 1, O_BR};
        vecs[8]  = '{5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 1, 0, 0, 1, O_BR};
        vecs[9]  = '{5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1, 0, 0, 1, O_MD};
        vecs[10] = '{5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, 0, 1, 0, O_MW};
        vecs[11] = '{5'd9, 5'd0, 5'd9, 1, 0, 1, 0, 0, 0, 1, 1, O_LU};
        vecs[12] = '{5'd5, 5'd0, 5'd5, 1, 0, 1, 0, 1, 0, 1, 0, O_MW};

        clear_inputs();
        @(negedge clk);
        #1;
        chk("reset_outputs_forced_low", O_NONE);
        next_cycle();
        rst_n = 1'b1;
        #1;
        chk("after_reset_idle", O_NONE);
        chk_cnt("after_reset_cnt", 4'd0);
        next_cycle();

        for (int i = 0; i < 13; i++) begin
            do_reset();
            rs1Id = vecs[i].rs1; rs2Id = vecs[i].rs2; rdEx = vecs[i].rd;
            useRs1Id = vecs[i].u1; useRs2Id = vecs[i].u2; memReadEx = vecs[i].mr;
            branchTakenEx = vecs[i].br; mulDivStartEx = vecs[i].md; mulDivDone = vecs[i].done;
            memAccessMem = vecs[i].ma; dmemReady = vecs[i].rdy;
            #1;
            chk($sformatf("vec%0d", i), vecs[i].exp);
            next_cycle();
        end

        // Load-use: one stall cycle, then clear; count 1
        do_reset();
        memReadEx = 1'b1; rdEx = 5'd5; rs2Id = 5'd5; useRs2Id = 1'b1;
        #1; chk("lu_stall", O_LU);
        next_cycle();
        memReadEx = 1'b0;
        #1; chk("lu_release", O_NONE);
        chk_cnt("lu_cnt", 4'd1);
        next_cycle();

        // Branch flush does not count as a stall
        do_reset();
        branchTakenEx = 1'b1;
        #1; chk("br_flush", O_BR);
        next_cycle();
        branchTakenEx = 1'b0;
        #1; chk_cnt("br_cnt", 4'd0);
        next_cycle();

        // Mul/div: 4 stall cycles, done on 5th
        do_reset();
        mulDivStartEx = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1; chk($sformatf("md_stall%0d", i), O_MD);
            next_cycle();
        end
        mulDivDone = 1'b1;
        #1; chk("md_done_release", O_NONE);
        next_cycle();
        mulDivDone = 1'b0; mulDivStartEx = 1'b0;
        #1; chk("md_back_to_run", O_NONE);
        chk_cnt("md_cnt", 4'd4);
        next_cycle();

        // Mul/div with done arriving during a 3-cycle DMEM wait
        do_reset();
        mulDivStartEx = 1'b1;
        #1; chk("mw_entry", O_MD);
        next_cycle();
        #1; chk("mw_muldiv", O_MD);
        next_cycle();
        memAccessMem = 1'b1; dmemReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            mulDivDone = (i == 1);
            #1; chk($sformatf("mw_freeze%0d", i), O_MW);
            next_cycle();
        end
        mulDivDone = 1'b0; dmemReady = 1'b1;
        #1; chk("mw_release", O_NONE);
        next_cycle();
        mulDivStartEx = 1'b0; memAccessMem = 1'b0;
        #1; chk("mw_run", O_NONE);
        chk_cnt("mw_cnt", 4'd5);
        next_cycle();

        // Timeout: abort on the 8th MULDIV cycle
        do_reset();
        mulDivStartEx = 1'b1;
        #1; chk("to_entry", O_MD);
        next_cycle();
        for (int i = 1; i < 8; i++) begin
            #1; chk($sformatf("to_wait%0d", i), O_MD);
            next_cycle();
        end
        #1; chk("to_abort", O_AB);
        next_cycle();
        mulDivStartEx = 1'b0;
        #1; chk("to_run", O_NONE);
        chk_cnt("to_cnt", 4'd8);
        next_cycle();

        // Reset mid-MULDIV: outputs low, then RUN with cleared count
        do_reset();
        mulDivStartEx = 1'b1;
        next_cycle();
        next_cycle();
        rst_n = 1'b0;
        #1; chk("rst_mid_md", O_NONE);
        next_cycle();
        rst_n = 1'b1; mulDivStartEx = 1'b0;
        #1; chk("rst_then_run", O_NONE);
        chk_cnt("rst_cnt", 4'd0);
        next_cycle();

        // Saturation and clear priority
        do_reset();
        memAccessMem = 1'b1; dmemReady = 1'b0;
        for (int i = 0; i < 20; i++) next_cycle();
        #1; chk_cnt("sat_cnt", 4'd15);
        clrStallCnt = 1'b1;
        next_cycle();
        #1; chk_cnt("clr_over_inc", 4'd0);
        clrStallCnt = 1'b0; memAccessMem = 1'b0; dmemReady = 1'b1;
        next_cycle();
        #1; chk_cnt("clr_hold", 4'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hazard_control_unit.md
Name: hazard_control_unit

Overview:
Pipeline sequencing controller for the 5-stage core. It generates the per-stage stall, flush and bubble controls around the operand forwarding network, and it tracks multi-cycle execute operations and data-memory wait states. It resolves load-use hazards, which forwarding cannot cover, as well as taken-branch flushes, mul/div occupancy and DMEM back-pressure. It also keeps a saturating stall-cycle performance counter.

Parameters:
CNT_W, 32, width of stall-cycle performance counter
MD_TIMEOUT, 64, max cycles in MULDIV before abort (must be >= 2)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
rs1Id  input  5  ID-stage source register 1
rs2Id  input  5  ID-stage source register 2
useRs1Id  input  1  ID instruction reads rs1
useRs2Id  input  1  ID instruction reads rs2
rdEx  input  5  EX-stage destination
memReadEx  input  1  EX instruction is a load
branchTakenEx  input  1  EX resolved taken branch/jump
mulDivStartEx  input  1  EX instruction is mul/div (level, held while in EX)
mulDivDone  input  1  mul/div result valid (1-cycle pulse)
memAccessMem  input  1  MEM instruction accesses DMEM
dmemReady  input  1  DMEM completes access this cycle
clrStallCnt  input  1  synchronous clear of counter
stallIf  output  1  hold PC
stallId  output  1  hold IF/ID register
stallEx  output  1  hold ID/EX register
stallMem  output  1  hold EX/MEM register
flushId  output  1  zero IF/ID register
bubbleEx  output  1  load NOP into ID/EX
bubbleMem  output  1  load NOP into EX/MEM
mulDivAbort  output  1  1-cycle pulse on MD timeout
stallCnt  output  CNT_W  saturating stall-cycle count

Behaviour:
- State register: RUN, MULDIV. Also holds doneSeen flag, mdCnt (clog2(MD_TIMEOUT+1) bits) and stallCnt. All update on clk rising edge.
- rst_n low at an edge: state=RUN, doneSeen=0, mdCnt=0, stallCnt=0. All control outputs are forced 0 combinationally while rst_n is low. Reset mid-MULDIV abandons the op with no abort pulse.
- memWait = memAccessMem & !dmemReady. It has top priority in any state.
  - Outputs: stallIf=stallId=stallEx=stallMem=1; all flush/bubble outputs 0.
  - State is unchanged.
  - mulDivDone during memWait sets doneSeen.
  - branchTakenEx is not acted on until memWait drops; EX is frozen, so the branch is re-presented then.
- MULDIV is entered from RUN when mulDivStartEx=1 and !memWait and !branchTakenEx. The entry cycle already stalls.
- In MULDIV (no memWait): stallIf=stallId=stallEx=1, bubbleMem=1, mdCnt increments.
- MULDIV exit when (mulDivDone | doneSeen) & !memWait:
  - That cycle drives no stall; the EX result advances.
  - Next state is RUN; doneSeen and mdCnt clear.
- MULDIV abort when mdCnt==MD_TIMEOUT-1 without done:
  - mulDivAbort=1 for that cycle.
  - Outputs are the same as the exit cycle; next state is RUN.
- RUN priority, highest first, evaluated when !memWait:
  1. branchTakenEx: flushId=1, bubbleEx=1, no stalls. This overrides load-use and mul/div start.
  2. mulDivStartEx: stallIf=stallId=stallEx=1, bubbleMem=1, go to MULDIV.
  3. Load-use: memReadEx & rdEx!=0 & ((useRs1Id & rs1Id==rdEx) | (useRs2Id & rs2Id==rdEx)). Response is stallIf=stallId=1, bubbleEx=1, exactly one cycle; the condition clears naturally next cycle.
  4. Otherwise all outputs are 0.
- stallCnt:
  - Increments by 1 each cycle stallIf=1, saturating at all-ones.
  - clrStallCnt has priority over increment (count becomes 0).
  - Not affected by flushes alone.
- Register x0 never triggers a load-use hazard.

Test Plan:
- Load-use: memReadEx=1, rdEx=5, rs2Id=5, useRs2Id=1 for 1 cycle, then memReadEx=0 -> stallIf=stallId=bubbleEx=1 for exactly 1 cycle, then all 0; stallCnt=1.
- x0 and unused operand: rdEx=0 with rs1Id=0; then rdEx=7, rs1Id=7, useRs1Id=0 -> no stall in either case.
- Mul/div: mulDivStartEx held, mulDivDone pulsed on the 5th cycle after start -> stallIf/stallId/stallEx/bubbleMem high for 4 cycles, low on the done cycle, state back to RUN; stallCnt=4.
- Mul/div with memWait overlap: done arrives during a 3-cycle dmemReady=0 window -> full freeze for 3 cycles, doneSeen set, and the first cycle after dmemReady=1 releases with no stall.
- Timeout: MD_TIMEOUT=8, no done -> mulDivAbort pulses on the 8th MULDIV cycle, then RUN.
- Branch versus load-use in the same cycle: flushId=bubbleEx=1 and stallIf=0. Also assert rst_n=0 mid-MULDIV -> all outputs 0 and the next cycle is RUN with stallCnt=0.
